// File: rtl/fp_normalize16_arbiter_if.sv
// Requester and result bus of the shared fp16 normalizer arbiter.
// Each req_valid[k]/req_ready[k] pair and out_valid/out_ready follow one rule:
// a transfer happens on a rising clk edge where both valid and ready are high.
// A source must hold its valid and payload until that edge; ready may depend on valid.
interface fp_normalize16_arbiter_if #(
    parameter int NREQ = 4,
    parameter int TAGW = 4,
    parameter int XW   = 20,
    parameter int NW   = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XW-1:0]   req_data;
    logic [NREQ-1:0]      req_under;
    logic [NREQ*TAGW-1:0] req_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [IDW-1:0]       out_id;
    logic [TAGW-1:0]      out_tag;
    logic [NW-1:0]        out_data;
    logic                 out_under;
    logic                 out_inexact;

    modport master (
        output req_valid, req_data, req_under, req_tag, out_ready,
        input  req_ready, out_valid, out_id, out_tag, out_data, out_under, out_inexact
    );

    modport slave (
        input  req_valid, req_data, req_under, req_tag, out_ready,
        output req_ready, out_valid, out_id, out_tag, out_data, out_under, out_inexact
    );
endinterface

// File: rtl/fp_normalize16_arbiter.sv
// Round-robin arbiter sharing one 2-stage fp16 normalizer among NREQ requesters.
// Define FPN16_ARB_PRIO_EN to give requester 0 strict priority over the round robin.
module fp_normalize16_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int TAGW = 4,
    parameter int XW   = 20,
    parameter int NW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    flush,
    fp_normalize16_arbiter_if.slave bus,
    output logic [XW-1:0]           norm_i,
    output logic                    norm_under_i,
    output logic                    norm_ce,
    input  logic [NW-1:0]           norm_o,
    input  logic                    norm_under_o,
    input  logic                    norm_inexact_o
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  rr_next;
    logic [IDW-1:0]  gid;
    logic            found;
    logic            grant_any;
    logic            advance;
    logic [TAGW-1:0] gtag;
    int              arb_idx;

    logic [LAT-1:0]  pv;
    logic [IDW-1:0]  pid  [LAT];
    logic [TAGW-1:0] ptag [LAT];

    // The normalizer and the tracking pipe move together; a held result freezes both.
    assign advance = ~rst & ce & ~flush & (~pv[LAT-1] | bus.out_ready);
    assign norm_ce = advance | (~rst & ce & flush);

    always_comb begin
        arb_idx = 0;
        found   = 1'b0;
        gid     = '0;
`ifdef FPN16_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < NREQ - 1; i++) begin
                arb_idx = ((rr_ptr == '0) ? 1 : int'(rr_ptr)) + i;
                if (arb_idx >= NREQ) arb_idx = arb_idx - (NREQ - 1);
                if (!found && bus.req_valid[IDW'(arb_idx)]) begin
                    found = 1'b1;
                    gid   = IDW'(arb_idx);
                end
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
            if (!found && bus.req_valid[IDW'(arb_idx)]) begin
                found = 1'b1;
                gid   = IDW'(arb_idx);
            end
        end
`endif
    end

    always_comb begin
        rr_next = rr_ptr;
`ifdef FPN16_ARB_PRIO_EN
        // A priority win by requester 0 leaves the rotation among 1..NREQ-1 untouched.
        if (gid != '0) rr_next = (int'(gid) == NREQ - 1) ? IDW'(1) : gid + 1'b1;
`else
        rr_next = (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
`endif
    end

    always_comb begin
        grant_any    = found & advance;
        norm_i       = '0;
        norm_under_i = 1'b0;
        gtag         = '0;
        if (grant_any) begin
            norm_i       = bus.req_data[int'(gid)*XW +: XW];
            norm_under_i = bus.req_under[gid];
            gtag         = bus.req_tag[int'(gid)*TAGW +: TAGW];
        end
    end

    assign bus.req_ready = grant_any ? (NREQ'(1) << gid) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            pv     <= '0;
            for (int i = 0; i < LAT; i++) begin
                pid[i]  <= '0;
                ptag[i] <= '0;
            end
        end else if (ce & flush) begin
            pv <= '0;
        end else if (advance) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i]   <= pv[i-1];
                pid[i]  <= pid[i-1];
                ptag[i] <= ptag[i-1];
            end
            pv[0]   <= grant_any;
            pid[0]  <= gid;
            ptag[0] <= gtag;
            if (grant_any) rr_ptr <= rr_next;
        end
    end

    assign bus.out_valid   = pv[LAT-1];
    assign bus.out_id      = pid[LAT-1];
    assign bus.out_tag     = ptag[LAT-1];
    assign bus.out_data    = norm_o;
    assign bus.out_under   = norm_under_o;
    assign bus.out_inexact = norm_inexact_o;
endmodule

// File: tb/tb_fp_normalize16_arbiter.sv
// Bench for fp_normalize16_arbiter: behavioural normalizer, arbitration model and result scoreboard.
module tb_fp_normalize16_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int TAGW = 4;
  localparam int XW   = 20;
  localparam int NW   = 16;
  localparam int IDW  = 2;
  localparam int W    = IDW + TAGW + NW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, ce, flush;
  always #5 clk = ~clk;

  logic [XW-1:0] norm_i;
  logic          norm_under_i, norm_ce;
  logic [NW-1:0] norm_o;
  logic          norm_under_o, norm_inexact_o;

  fp_normalize16_arbiter_if #(.NREQ(NREQ), .TAGW(TAGW), .XW(XW), .NW(NW)) bus ();

  fp_normalize16_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW), .XW(XW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(bus),
    .norm_i(norm_i), .norm_under_i(norm_under_i), .norm_ce(norm_ce),
    .norm_o(norm_o), .norm_under_o(norm_under_o), .norm_inexact_o(norm_inexact_o)
  );

  int total = 0;
  int bad = 0;

  // Reference normalizer: shift mantissa up to its leading one, adjust exponent, report dropped bits.
  function automatic logic [NW:0] ref_norm(input logic [XW-1:0] x);
    logic [12:0] m;
    int e;
    m = x[12:0];
    e = int'(x[18:13]);
    if (m == 13'd0) return {1'b0, x[19], 15'd0};
    while (m[12] == 1'b0) begin
      m = m << 1;
      e = e - 1;
    end
    if (e < 0) e = 0;
    return {|m[1:0], x[19], e[4:0], m[11:2]};
  endfunction

  // Environment normalizer: two stages clocked by norm_ce.
  logic [NW:0] n1, n2;
  logic        u1, u2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n1 <= '0; n2 <= '0; u1 <= 1'b0; u2 <= 1'b0;
    end else if (norm_ce) begin
      n1 <= ref_norm(norm_i);
      u1 <= norm_under_i;
      n2 <= n1;
      u2 <= u1;
    end
  end
  assign norm_o         = n2[NW-1:0];
  assign norm_inexact_o = n2[NW];
  assign norm_under_o   = u2;

  // ---------------- stimulus storage ----------------
  logic [XW-1:0]   d_arr [NREQ];
  logic [TAGW-1:0] t_arr [NREQ];
  logic [NREQ-1:0] u_vec;
  always_comb begin
    bus.req_under = u_vec;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_data[k*XW +: XW]     = d_arr[k];
      bus.req_tag[k*TAGW +: TAGW]  = t_arr[k];
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q [$];
  int           age_q [$];
  int           rr_m;
  bit           mon_en = 1'b0;
  bit           s_live = 1'b0;
  bit           s_adv, s_fl, s_pop;
  int           s_g;
  logic [W-1:0] s_item;

  function automatic int ref_grant(input logic [NREQ-1:0] rv, input int rr);
`ifdef FPN16_ARB_PRIO_EN
    int start;
    if (rv[0]) return 0;
    start = (rr < 1) ? 1 : rr;
    for (int i = 0; i < NREQ - 1; i++) begin
      int k;
      k = 1 + ((start - 1 + i) % (NREQ - 1));
      if (rv[k]) return k;
    end
    return -1;
`else
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (rr + i) % NREQ;
      if (rv[k]) return k;
    end
    return -1;
`endif
  endfunction

  function automatic int ref_next_rr(input int g, input int rr);
`ifdef FPN16_ARB_PRIO_EN
    if (g == 0) return rr;
    return 1 + (g % (NREQ - 1));
`else
    return (g + 1) % NREQ;
`endif
  endfunction

  // Scoreboard: compare outputs and grants at negedge, apply the cycle's effect at posedge.
  always @(negedge clk) begin : monitor
    bit              exp_v, adv;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic [NW:0]     rn;
    if (mon_en && !rst) begin
      exp_v = (exp_q.size() > 0) && (age_q[0] == LAT);
      total++;
      if (bus.out_valid !== exp_v) begin
        bad++;
        $display("FAIL sb_out_valid t=%0t got=%b want=%b", $time, bus.out_valid, exp_v);
      end
      if (exp_v && bus.out_valid === 1'b1) begin
        total++;
        if ({bus.out_id, bus.out_tag, bus.out_data, bus.out_under, bus.out_inexact} !== exp_q[0]) begin
          bad++;
          $display("FAIL sb_result t=%0t got={id,tag,data,u,x}=%h want=%h", $time,
                   {bus.out_id, bus.out_tag, bus.out_data, bus.out_under, bus.out_inexact}, exp_q[0]);
        end
      end
      adv = ce && !flush && (!exp_v || bus.out_ready);
      g = adv ? ref_grant(bus.req_valid, rr_m) : -1;
      exp_rdy = (g >= 0) ? (4'(1) << g) : 4'd0;
      total++;
      if (bus.req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL sb_req_ready t=%0t got=%b want=%b", $time, bus.req_ready, exp_rdy);
      end
      total++;
      if (norm_ce !== (adv || (ce && flush))) begin
        bad++;
        $display("FAIL sb_norm_ce t=%0t got=%b want=%b", $time, norm_ce, adv || (ce && flush));
      end
      s_adv = adv;
      s_fl  = ce && flush;
      s_pop = exp_v;
      s_g   = g;
      if (g >= 0) begin
        rn = ref_norm(d_arr[g]);
        s_item = {IDW'(g), t_arr[g], rn[NW-1:0], u_vec[g], rn[NW]};
      end
      s_live = 1'b1;
    end else begin
      s_live = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin : model_update
    if (rst) begin
      exp_q.delete();
      age_q.delete();
      rr_m = 0;
    end else if (s_live) begin
      if (s_fl) begin
        exp_q.delete();
        age_q.delete();
      end else if (s_adv) begin
        if (s_pop) begin
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        foreach (age_q[i]) age_q[i]++;
        if (s_g >= 0) begin
          exp_q.push_back(s_item);
          age_q.push_back(1);
          rr_m = ref_next_rr(s_g, rr_m);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_operands();
    for (int k = 0; k < NREQ; k++) begin
      d_arr[k] = XW'($urandom);
      t_arr[k] = TAGW'($urandom_range(0, 15));
    end
    u_vec = NREQ'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    ce = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [NW:0] rn;
    randomize_operands();
    rst = 1'b1;
    ce = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || norm_ce !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got v=%b rdy=%b nce=%b want 0 0000 0", bus.out_valid, bus.req_ready, norm_ce);
    end
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant got=%b want=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_early_valid got=%b want=0", bus.out_valid);
    end
    tick();
    @(negedge clk);
    rn = ref_norm(d_arr[0]);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== rn[NW-1:0]) begin
      bad++;
      $display("FAIL reset_first_result got v=%b id=%0d data=%h want v=1 id=0 data=%h",
               bus.out_valid, bus.out_id, bus.out_data, rn[NW-1:0]);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    randomize_operands();
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 8) bus.req_valid = 4'b0000;
      @(negedge clk);
      if (cyc < 8) begin
        total++;
        if (bus.req_ready !== (4'(1) << (cyc % 4))) begin
          bad++;
          $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, bus.req_ready, 4'(1) << (cyc % 4));
        end
      end
      if (cyc >= 2) begin
        total++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_id) != (cyc - 2) % 4) begin
          bad++;
          $display("FAIL rr_out_id cyc=%0d got v=%b id=%0d want v=1 id=%0d", cyc, bus.out_valid, bus.out_id, (cyc - 2) % 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          handshakes;
    logic [NW:0] rn;
    do_reset();
    randomize_operands();
    handshakes = 0;
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 13; cyc++) begin
      bus.out_ready = (cyc < 3 || cyc >= 8);
      if (cyc >= 8) bus.req_valid = 4'b0000;
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready) handshakes++;
      if (cyc >= 3 && cyc < 8) begin
        rn = ref_norm(d_arr[1]);
        total++;
        if (norm_ce !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
            bus.out_id !== 2'd1 || bus.out_tag !== t_arr[1] || bus.out_data !== rn[NW-1:0]) begin
          bad++;
          $display("FAIL bp_stall cyc=%0d got nce=%b rdy=%b v=%b id=%0d tag=%h data=%h want 0 0000 1 1 %h %h",
                   cyc, norm_ce, bus.req_ready, bus.out_valid, bus.out_id, bus.out_tag, bus.out_data, t_arr[1], rn[NW-1:0]);
        end
      end
      tick();
    end
    total++;
    if (handshakes != 3) begin
      bad++;
      $display("FAIL bp_count got=%0d want=3", handshakes);
    end
  endtask

  task automatic test_flush();
    do_reset();
    randomize_operands();
    t_arr[0] = 4'd3;
    t_arr[1] = 4'd7;
    for (int cyc = 0; cyc < 10; cyc++) begin
      flush = (cyc == 2);
      bus.out_ready = (cyc != 2);
      case (cyc)
        0: bus.req_valid = 4'b0001;
        1: bus.req_valid = 4'b0010;
        2: bus.req_valid = 4'b1111;
        6: bus.req_valid = 4'b1111;
        default: bus.req_valid = 4'b0000;
      endcase
      @(negedge clk);
      if (cyc == 2) begin
        total++;
        if (bus.req_ready !== 4'b0000 || norm_ce !== 1'b1) begin
          bad++;
          $display("FAIL flush_cycle got rdy=%b nce=%b want 0000 1", bus.req_ready, norm_ce);
        end
      end
      if (cyc >= 3 && cyc <= 6) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL flush_out_valid cyc=%0d got=%b want=0", cyc, bus.out_valid);
        end
      end
      if (cyc == 6) begin
        total++;
        if (bus.req_ready !== 4'b0100) begin
          bad++;
          $display("FAIL flush_rr_resume got=%b want=0100", bus.req_ready);
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_ce_toggle();
    do_reset();
    randomize_operands();
    bus.req_valid = 4'b0001;
    for (int cyc = 0; cyc < 4; cyc++) begin
      ce = (cyc % 2 == 0);
      @(negedge clk);
      total++;
      case (cyc)
        0: if (bus.req_ready !== 4'b0001) begin
             bad++; $display("FAIL ce_grant0 got=%b want=0001", bus.req_ready);
           end
        1: if (bus.req_ready !== 4'b0000 || norm_ce !== 1'b0 || bus.out_valid !== 1'b0) begin
             bad++; $display("FAIL ce_low1 got rdy=%b nce=%b v=%b want 0000 0 0", bus.req_ready, norm_ce, bus.out_valid);
           end
        2: if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
             bad++; $display("FAIL ce_high2 got v=%b rdy=%b want 0 0001", bus.out_valid, bus.req_ready);
           end
        default: if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0) begin
             bad++; $display("FAIL ce_result got v=%b id=%0d want 1 0", bus.out_valid, bus.out_id);
           end
      endcase
      tick();
    end
    ce = 1'b1;
    bus.req_valid = 4'b0000;
    repeat (4) tick();
  endtask

`ifdef FPN16_ARB_PRIO_EN
  task automatic test_priority();
    logic [NREQ-1:0] want;
    do_reset();
    randomize_operands();
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 6) bus.req_valid = 4'b1110;
      case (cyc)
        6: want = 4'b0010;
        7: want = 4'b0100;
        8: want = 4'b1000;
        9: want = 4'b0010;
        default: want = 4'b0001;
      endcase
      @(negedge clk);
      total++;
      if (bus.req_ready !== want) begin
        bad++;
        $display("FAIL prio_grant cyc=%0d got=%b want=%b", cyc, bus.req_ready, want);
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (4) tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      randomize_operands();
      bus.req_valid = NREQ'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      ce = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if (cyc == 200) begin
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
          bad++;
          $display("FAIL rand_midreset got v=%b rdy=%b want 0 0000", bus.out_valid, bus.req_ready);
        end
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    ce = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain got v=%b pending=%0d want 0 0", bus.out_valid, exp_q.size());
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    randomize_operands();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_ce_toggle();
`ifdef FPN16_ARB_PRIO_EN
    test_priority();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
